// File: rtl/vmm_result_reader.sv
`timescale 1ns/1ps
// vmm_result_reader: steps the VMM result port one element at a time and streams each element,
// tagged with its (row,col), over valid/ready while keeping a wrapping checksum and a sticky index check.
// Latency: REQ->valid 2 cycles, one element per 3 cycles with ready high; a stalled sink holds SEND.

module vmm_result_reader #(
   parameter int         L        = 5,
   parameter int         N        = 5,
   parameter logic [2:0] RD_STATE = 3'd4,
   parameter int         CSUM_W   = 16
) (
   input  logic              vmm_clk,
   input  logic              rst_,
   input  logic              start_i,
   input  logic [2:0]        vmm_state_i,
   input  logic [9:0]        vmm_out_i,
   input  logic [L-1:0]      vmm_i,
   input  logic [N-1:0]      vmm_j,
   output logic              next_o,
   output logic              done_o,
   output logic              elem_valid_o,
   input  logic              elem_ready_i,
   output logic [9:0]        elem_data_o,
   output logic [L-1:0]      elem_row_o,
   output logic [N-1:0]      elem_col_o,
   output logic              elem_last_o,
   output logic              busy_o,
   output logic [CSUM_W-1:0] checksum_o,
   output logic              idx_err_o
);

   localparam int CNT_W = $clog2(L*N+1);
   // The add is done at least element-wide so a checksum narrower than the data still wraps mod 2^CSUM_W.
   localparam int SUM_W = (CSUM_W > 10) ? CSUM_W : 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [L-1:0]     exp_row;
   logic [N-1:0]     exp_col;
   logic [SUM_W-1:0] sum_wide;

   assign sum_wide = SUM_W'(checksum_o) + SUM_W'(elem_data_o);

   // Readout sequencer: every output is registered so strobes to the VMM are glitch-free.
   always_ff @(posedge vmm_clk or negedge rst_) begin
      if (!rst_) begin
         state        <= S_IDLE;
         count        <= '0;
         exp_row      <= '0;
         exp_col      <= '0;
         next_o       <= 1'b0;
         done_o       <= 1'b0;
         elem_valid_o <= 1'b0;
         elem_data_o  <= '0;
         elem_row_o   <= '0;
         elem_col_o   <= '0;
         elem_last_o  <= 1'b0;
         busy_o       <= 1'b0;
         checksum_o   <= '0;
         idx_err_o    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Results from the previous readout stay visible until a start is accepted.
               if (start_i && vmm_state_i == RD_STATE) begin
                  state      <= S_REQ;
                  next_o     <= 1'b1;
                  busy_o     <= 1'b1;
                  count      <= '0;
                  exp_row    <= '0;
                  exp_col    <= '0;
                  checksum_o <= '0;
                  idx_err_o  <= 1'b0;
               end
            end
            S_REQ: begin
               // The VMM registers the element on this edge; its index is the one being stepped out.
               next_o     <= 1'b0;
               elem_row_o <= vmm_i;
               elem_col_o <= vmm_j;
               if (vmm_i != exp_row || vmm_j != exp_col)
                  idx_err_o <= 1'b1;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               elem_data_o  <= vmm_out_i;
               elem_valid_o <= 1'b1;
               elem_last_o  <= (count == CNT_W'(L*N-1));
               state        <= S_SEND;
            end
            S_SEND: begin
               if (elem_ready_i) begin
                  elem_valid_o <= 1'b0;
                  elem_last_o  <= 1'b0;
                  checksum_o   <= sum_wide[CSUM_W-1:0];
                  count        <= count + CNT_W'(1);
                  if (exp_col == N'(N-1)) begin
                     exp_col <= '0;
                     exp_row <= exp_row + L'(1);
                  end else begin
                     exp_col <= exp_col + N'(1);
                  end
                  if (elem_last_o) begin
                     state  <= S_FIN;
                     done_o <= 1'b1;
                  end else begin
                     state  <= S_REQ;
                     next_o <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vmm_result_reader.sv
`timescale 1ns/1ps
// Bench for vmm_result_reader: directed runs against a small VMM result-port model, with a
// scoreboard queue per instance filled by the stimulus and drained by a negedge monitor.

module tb_vmm_result_reader;

   logic vmm_clk = 1'b0;
   always #5 vmm_clk = ~vmm_clk;

   logic       rst_      = 1'b0;
   logic [2:0] vmm_state = 3'd0;

   // Instance A: 2x2 result matrix, 16-bit checksum
   logic        start_a = 1'b0, ready_a = 1'b1;
   logic        next_a, done_a, val_a, last_a, busy_a, err_a;
   logic [9:0]  vmm_out_a = '0, data_a;
   logic [1:0]  vi_a, vj_a, row_a, col_a;
   logic [15:0] csum_a;

   // Instance B: 1x2 result matrix, 4-bit checksum
   logic        start_b = 1'b0, ready_b = 1'b1;
   logic        next_b, done_b, val_b, last_b, busy_b, err_b;
   logic [9:0]  vmm_out_b = '0, data_b;
   logic [0:0]  vi_b, row_b;
   logic [1:0]  vj_b, col_b;
   logic [3:0]  csum_b;

   vmm_result_reader #(.L(2), .N(2), .RD_STATE(3'd4), .CSUM_W(16)) dut_a (
      .vmm_clk(vmm_clk), .rst_(rst_), .start_i(start_a), .vmm_state_i(vmm_state),
      .vmm_out_i(vmm_out_a), .vmm_i(vi_a), .vmm_j(vj_a), .next_o(next_a), .done_o(done_a),
      .elem_valid_o(val_a), .elem_ready_i(ready_a), .elem_data_o(data_a), .elem_row_o(row_a),
      .elem_col_o(col_a), .elem_last_o(last_a), .busy_o(busy_a), .checksum_o(csum_a),
      .idx_err_o(err_a));

   vmm_result_reader #(.L(1), .N(2), .RD_STATE(3'd4), .CSUM_W(4)) dut_b (
      .vmm_clk(vmm_clk), .rst_(rst_), .start_i(start_b), .vmm_state_i(vmm_state),
      .vmm_out_i(vmm_out_b), .vmm_i(vi_b), .vmm_j(vj_b), .next_o(next_b), .done_o(done_b),
      .elem_valid_o(val_b), .elem_ready_i(ready_b), .elem_data_o(data_b), .elem_row_o(row_b),
      .elem_col_o(col_b), .elem_last_o(last_b), .busy_o(busy_b), .checksum_o(csum_b),
      .idx_err_o(err_b));

   // VMM model A: pointer names the element the next step will emit; data registered on next.
   int         ptr_a     = 0;
   logic       bad_first = 1'b0;
   logic       rewind    = 1'b0;
   logic [9:0] c_a [4]   = '{10'd1, 10'd2, 10'd3, 10'd4};
   assign vi_a = 2'(ptr_a / 2);
   assign vj_a = (bad_first && ptr_a == 0) ? 2'd1 : 2'(ptr_a % 2);
   always @(posedge vmm_clk) begin
      if (rewind) ptr_a <= 0;
      else if (next_a) begin
         vmm_out_a <= c_a[ptr_a % 4];
         ptr_a     <= ptr_a + 1;
      end
   end

   // VMM model B: both elements are 9
   int ptr_b = 0;
   assign vi_b = 1'b0;
   assign vj_b = 2'(ptr_b % 2);
   always @(posedge vmm_clk) begin
      if (next_b) begin
         vmm_out_b <= 10'd9;
         ptr_b     <= ptr_b + 1;
      end
   end

   typedef struct {
      logic [9:0] d;
      logic [1:0] r;
      logic [1:0] c;
      logic       l;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int checks = 0, errors = 0;
   int next_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int d, input int r, input int c, input int l);
      exp_t e;
      e.d = 10'(d);
      e.r = 2'(r);
      e.c = 2'(c);
      e.l = 1'(l);
      return e;
   endfunction

   // Monitor A: compare the head entry on every valid cycle (so stalls must hold), pop on handshake.
   always @(negedge vmm_clk) begin
      if (rst_) begin
         if (next_a) next_cnt_a++;
         if (done_a) done_cnt_a++;
         chk("a_next_done_overlap", 32'(next_a & done_a), 32'd0);
         if (val_a) begin
            chk("a_elem_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
               chk("a_data", 32'(data_a), 32'(q_a[0].d));
               chk("a_row",  32'(row_a),  32'(q_a[0].r));
               chk("a_col",  32'(col_a),  32'(q_a[0].c));
               chk("a_last", 32'(last_a), 32'(q_a[0].l));
               if (ready_a) void'(q_a.pop_front());
            end
         end
      end
   end

   // Monitor B
   always @(negedge vmm_clk) begin
      if (rst_) begin
         if (done_b) done_cnt_b++;
         if (val_b) begin
            chk("b_elem_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
               chk("b_data", 32'(data_b), 32'(q_b[0].d));
               chk("b_row",  32'(row_b),  32'(q_b[0].r));
               chk("b_col",  32'(col_b),  32'(q_b[0].c));
               chk("b_last", 32'(last_b), 32'(q_b[0].l));
               if (ready_b) void'(q_b.pop_front());
            end
         end
      end
   end

   task automatic push_std(input bit bad);
      q_a.push_back(mk(1, 0, bad ? 1 : 0, 0));
      q_a.push_back(mk(2, 0, 1, 0));
      q_a.push_back(mk(3, 1, 0, 0));
      q_a.push_back(mk(4, 1, 1, 1));
   endtask

   task automatic do_rewind();
      @(posedge vmm_clk); #1 rewind = 1'b1;
      @(posedge vmm_clk); #1 rewind = 1'b0;
   endtask

   task automatic pulse_start_a();
      @(posedge vmm_clk); #1 start_a = 1'b1;
      @(posedge vmm_clk); #1 start_a = 1'b0;
   endtask

   task automatic check_outs_zero_a(input string nm);
      chk({nm, "_ctrl"}, 32'({next_a, done_a, val_a, last_a, busy_a, err_a}), 32'd0);
      chk({nm, "_data"}, 32'(data_a), 32'd0);
      chk({nm, "_idx"},  32'({row_a, col_a}), 32'd0);
      chk({nm, "_csum"}, 32'(csum_a), 32'd0);
   endtask

   // Wait for done on A within a cycle budget, optionally toggling ready every cycle.
   task automatic wait_done_a(input int budget, input bit tog);
      int n0;
      bit seen;
      n0   = done_cnt_a;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge vmm_clk);
         if (done_cnt_a != n0) begin
            seen = 1'b1;
            break;
         end
         @(posedge vmm_clk); #1;
         if (tog) ready_a = ~ready_a;
      end
      chk("a_done_within_budget", 32'(seen), 32'd1);
      @(posedge vmm_clk); #1;
      chk("a_busy_after_fin", 32'(busy_a), 32'd0);
      repeat (2) @(posedge vmm_clk);
      #1 chk("a_done_pulses", 32'(done_cnt_a - n0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int  n_next;
      int  n_done;
      bit  found;

      // Reset state
      #2 check_outs_zero_a("reset");
      chk("reset_b", 32'({next_b, done_b, val_b, busy_b, csum_b}), 32'd0);
      repeat (2) @(posedge vmm_clk);
      #1 rst_ = 1'b1;

      // 1) plain readout, ready high
      vmm_state = 3'd4;
      ready_a   = 1'b1;
      push_std(1'b0);
      n_next = next_cnt_a;
      pulse_start_a();
      wait_done_a(60, 1'b0);
      chk("t1_csum", 32'(csum_a), 32'd10);
      chk("t1_idx_err", 32'(err_a), 32'd0);
      chk("t1_next_cnt", 32'(next_cnt_a - n_next), 32'd4);
      chk("t1_q_drained", 32'(q_a.size()), 32'd0);

      // 2) ready toggling every cycle
      do_rewind();
      push_std(1'b0);
      n_next = next_cnt_a;
      pulse_start_a();
      wait_done_a(120, 1'b1);
      chk("t2_csum", 32'(csum_a), 32'd10);
      chk("t2_next_cnt", 32'(next_cnt_a - n_next), 32'd4);
      chk("t2_q_drained", 32'(q_a.size()), 32'd0);
      ready_a = 1'b1;

      // 3) start with the wrong VMM state is ignored and not remembered
      vmm_state = 3'd2;
      n_next    = next_cnt_a;
      @(posedge vmm_clk); #1 start_a = 1'b1;
      repeat (2) @(posedge vmm_clk);
      #1 start_a = 1'b0;
      vmm_state = 3'd4;
      for (int k = 0; k < 4; k++) begin
         @(posedge vmm_clk);
         #1 chk("t3_busy", 32'(busy_a), 32'd0);
      end
      chk("t3_next_cnt", 32'(next_cnt_a - n_next), 32'd0);
      chk("t3_csum_held", 32'(csum_a), 32'd10);

      // 4) wrong column reported on first step
      do_rewind();
      bad_first = 1'b1;
      push_std(1'b1);
      pulse_start_a();
      @(posedge vmm_clk);
      #1 chk("t4_idx_err_after_req", 32'(err_a), 32'd1);
      wait_done_a(60, 1'b0);
      chk("t4_idx_err_sticky", 32'(err_a), 32'd1);
      chk("t4_csum", 32'(csum_a), 32'd10);
      chk("t4_q_drained", 32'(q_a.size()), 32'd0);
      bad_first = 1'b0;

      // 5) reset while the second element is being offered
      do_rewind();
      push_std(1'b0);
      ready_a = 1'b1;
      pulse_start_a();
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge vmm_clk); #1;
         if (val_a && col_a == 2'd1) begin
            found   = 1'b1;
            ready_a = 1'b0;
            break;
         end
      end
      chk("t5_reached_2nd", 32'(found), 32'd1);
      #2 rst_ = 1'b0;
      #1 check_outs_zero_a("t5_reset");
      chk("t5_q_left", 32'(q_a.size()), 32'd3);
      q_a.delete();
      n_done = done_cnt_a;
      repeat (3) @(posedge vmm_clk);
      #1 rst_ = 1'b1;
      do_rewind();
      chk("t5_no_done", 32'(done_cnt_a - n_done), 32'd0);
      ready_a = 1'b1;
      push_std(1'b0);
      pulse_start_a();
      wait_done_a(60, 1'b0);
      chk("t5_csum_restart", 32'(csum_a), 32'd10);
      chk("t5_idx_err", 32'(err_a), 32'd0);
      chk("t5_q_drained", 32'(q_a.size()), 32'd0);

      // 6) narrow checksum wraps: 9 + 9 = 18 -> 2 mod 16
      q_b.push_back(mk(9, 0, 0, 0));
      q_b.push_back(mk(9, 0, 1, 1));
      n_done = done_cnt_b;
      @(posedge vmm_clk); #1 start_b = 1'b1;
      @(posedge vmm_clk); #1 start_b = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge vmm_clk);
         if (done_cnt_b != n_done) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_done_within_budget", 32'(found), 32'd1);
      repeat (2) @(posedge vmm_clk);
      #1 chk("t6_csum_wrap", 32'(csum_b), 32'd2);
      chk("t6_q_drained", 32'(q_b.size()), 32'd0);
      chk("t6_busy", 32'(busy_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
